// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, data width and the baud divisor helper.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and pulses tick on the wrap; clear restarts a bit period.
// Shared by transmit and (future) receive paths.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == CNT_LAST);
  assign tick = wrap && !clear;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || wrap) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, one byte per tx_start; 8N1/8N2, or 8E1/8O1 when UART_TX_PARITY_EN is defined.
// txd is registered (start bit begins the cycle after tx_start); tx_busy includes tx_start combinationally.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       txd
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam logic [2:0] DATA_LAST = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_tx: STOP_BITS must be 1 or 2 and PARITY_ODD 0 or 1");
  end

  uart_state_t               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic                      txd_q, txd_d;
  logic                      done_q, done_d;
  logic                      start_acc;
  logic                      bit_tick;
`ifdef UART_TX_PARITY_EN
  logic                      par_q, par_d;
`endif

  assign start_acc = (state_q == ST_IDLE) && tx_start;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(start_acc),
    .tick (bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    txd_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          shift_d   = tx_data;
          bit_cnt_d = 3'd0;
          state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
          par_d     = (^tx_data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      ST_START: begin
        if (bit_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_tick) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = 3'd0;
            state_d   = ST_IDLE;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is registered, so it is derived from where the FSM is going next.
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = par_q;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= 3'd0;
      txd_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
      done_q    <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end
`endif

  assign tx_busy = (state_q != ST_IDLE) || tx_start;
  assign tx_done = done_q;
  assign txd     = txd_q;

endmodule
